// File: rtl/hazard_control_unit_if.sv
// Hazard unit <-> F/D/E/W datapath bundle.
//   master : datapath side. Drives hazard sources and the multi-cycle handshake;
//            receives the forwarding selects and the stall/flush controls.
//   slave  : hazard_control_unit side.
// CNT_W must match the CNT_W of the hazard_control_unit instance.
interface hazard_control_unit_if #(parameter int CNT_W = 16);
  logic             RegWE_E_W, RegWE_W_W, RegWE_W_W2;
  logic [4:0]       A1_E, A2_E, A3_W, A4_W, A4_W2;
  logic [1:0]       PCSrcE;
  logic             mc_start_E, mc_done;
  logic [1:0]       fwdA_E, fwdB_E;
  logic             StallF, StallD, StallE, StallW;
  logic             FlushD, FlushE, FlushW;
  logic             mc_busy, mc_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output RegWE_E_W, RegWE_W_W, RegWE_W_W2, A1_E, A2_E, A3_W, A4_W, A4_W2,
           PCSrcE, mc_start_E, mc_done,
    input  fwdA_E, fwdB_E, StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW,
           mc_busy, mc_timeout, stall_count
  );

  modport slave (
    input  RegWE_E_W, RegWE_W_W, RegWE_W_W2, A1_E, A2_E, A3_W, A4_W, A4_W2,
           PCSrcE, mc_start_E, mc_done,
    output fwdA_E, fwdB_E, StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW,
           mc_busy, mc_timeout, stall_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the F/D/E/W core.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   hz    : slave side of hazard_control_unit_if
//     inputs  : hazard sources (write enables and addresses in W/W2, E operand
//               addresses), PCSrcE, mc_start_E/mc_done handshake
//     outputs : fwdA_E/fwdB_E (00 RF, 01 ALUResultW, 10 ReadData2),
//               Stall*/Flush*, mc_busy, sticky mc_timeout, saturating stall_count
// Hazard priority: reset > multi-cycle hold > load-use > branch.
module hazard_control_unit #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_control_unit_if.slave  hz
);
  localparam int TW = $clog2(MC_TIMEOUT);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             ack, ack_nxt;
  logic             to_q, to_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lu, mc_go, mc_hold, stall, br;

  // Forwarding, one selector per E operand. x0 never matches; W beats W2.
  logic [1:0][4:0] src;
  logic [1:0][1:0] fwd;
  assign src = {hz.A2_E, hz.A1_E};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    logic hit_w, hit_w2;
    assign hit_w  = hz.RegWE_E_W  && (hz.A3_W  == src[i]) && (src[i] != 5'd0);
    assign hit_w2 = hz.RegWE_W_W2 && (hz.A4_W2 == src[i]) && (src[i] != 5'd0);
    assign fwd[i] = hit_w ? 2'b01 : (hit_w2 ? 2'b10 : 2'b00);
  end

  // Load in W cannot forward this cycle: hold F/D/E one cycle, it comes
  // back via the W2 path next cycle.
  assign lu = hz.RegWE_W_W && (hz.A4_W != 5'd0) &&
              ((hz.A4_W == hz.A1_E) || (hz.A4_W == hz.A2_E));

  // ack masks the still-present mc_start_E of the instruction that just
  // finished (or aborted) so it is not launched a second time.
  assign mc_go = hz.mc_start_E && !ack;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    ack_nxt   = 1'b0;
    to_nxt    = to_q;
    mc_hold   = 1'b0;
    stall     = 1'b0;
    case (state)
      RUN: begin
        mc_hold = mc_go && !hz.mc_done && !lu;
        stall   = mc_hold || lu;
        if (mc_hold) begin
          state_nxt = MC_BUSY;
          timer_nxt = TW'(1);
        end
      end
      MC_BUSY: begin
        stall     = 1'b1;
        timer_nxt = timer + TW'(1);
        if (hz.mc_done) begin
          state_nxt = RUN;
          timer_nxt = '0;
          ack_nxt   = 1'b1;
        end else if (timer == TW'(MC_TIMEOUT - 1)) begin
          state_nxt = RUN;
          timer_nxt = '0;
          ack_nxt   = 1'b1;
          to_nxt    = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Branch flush only when nothing is holding E.
  assign br = (hz.PCSrcE != 2'b00) && !lu && (state == RUN) && !mc_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      timer <= '0;
      ack   <= 1'b0;
      to_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      ack   <= ack_nxt;
      to_q  <= to_nxt;
      if (stall && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
    end
  end

  // Combinational outputs are gated low for the whole time reset is held.
  assign hz.fwdA_E      = reset ? fwd[0] : 2'b00;
  assign hz.fwdB_E      = reset ? fwd[1] : 2'b00;
  assign hz.StallF      = reset && stall;
  assign hz.StallD      = reset && stall;
  assign hz.StallE      = reset && stall;
  assign hz.StallW      = 1'b0;
  assign hz.FlushW      = reset && stall;
  assign hz.FlushD      = reset && br;
  assign hz.FlushE      = reset && br;
  assign hz.mc_busy     = reset && (state == MC_BUSY);
  assign hz.mc_timeout  = to_q;
  assign hz.stall_count = cnt;
endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(CW)) hif();

  hazard_control_unit #(.MC_TIMEOUT(8), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  typedef struct packed {
    logic       rst;
    logic       we_e, we_w, we_w2;
    logic [4:0] a1, a2, a3, a4, a4w2;
    logic [1:0] pcsrc;
    logic       mcs, mcd;
  } stim_t;

  // {fwdA, fwdB, StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW, busy, timeout, count}
  typedef struct {
    string        nm;
    logic [16:0]  e;
  } sb_t;

  sb_t   sb[$];
  stim_t s;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic logic [16:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic st, input logic br, input logic busy,
                                     input logic to, input logic [CW-1:0] cnt);
    return {fa, fb, st, st, st, 1'b0, br, br, st, busy, to, cnt};
  endfunction

  task automatic apply(input string nm, input logic [16:0] e);
    sb_t it;
    @(posedge clk);
    #1;
    reset          = s.rst;
    hif.RegWE_E_W  = s.we_e;
    hif.RegWE_W_W  = s.we_w;
    hif.RegWE_W_W2 = s.we_w2;
    hif.A1_E       = s.a1;
    hif.A2_E       = s.a2;
    hif.A3_W       = s.a3;
    hif.A4_W       = s.a4;
    hif.A4_W2      = s.a4w2;
    hif.PCSrcE     = s.pcsrc;
    hif.mc_start_E = s.mcs;
    hif.mc_done    = s.mcd;
    it.nm = nm;
    it.e  = e;
    sb.push_back(it);
  endtask

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    t.rst = 1'b1;
    return t;
  endfunction

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    sb_t         it;
    logic [16:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        act = {hif.fwdA_E, hif.fwdB_E, hif.StallF, hif.StallD, hif.StallE, hif.StallW,
               hif.FlushD, hif.FlushE, hif.FlushW, hif.mc_busy, hif.mc_timeout,
               hif.stall_count};
        n_vec++;
        if (act !== it.e) begin
          n_err++;
          $display("FAIL %s: got %b expected %b", it.nm, act, it.e);
        end
      end
    end
  end

  initial begin
    hif.RegWE_E_W = 0; hif.RegWE_W_W = 0; hif.RegWE_W_W2 = 0;
    hif.A1_E = 0; hif.A2_E = 0; hif.A3_W = 0; hif.A4_W = 0; hif.A4_W2 = 0;
    hif.PCSrcE = 0; hif.mc_start_E = 0; hif.mc_done = 0;

    // reset holds everything low even with hazards present
    s = '0; s.we_w = 1; s.a4 = 5; s.a1 = 5; s.pcsrc = 2'b01; s.we_e = 1; s.a3 = 5;
    apply("reset_state", mk(2'b00, 2'b00, 0, 0, 0, 0, 0));
    s = idle();                                         apply("idle", mk(2'b00, 2'b00, 0, 0, 0, 0, 0));

    // load-use then W2 forward
    s = idle(); s.we_w = 1; s.a4 = 5; s.a1 = 5;         apply("lu_stall", mk(2'b00, 2'b00, 1, 0, 0, 0, 0));
    s = idle(); s.we_w2 = 1; s.a4w2 = 5; s.a1 = 5;      apply("lu_fwd_w2", mk(2'b10, 2'b00, 0, 0, 0, 0, 1));

    // forwarding priority and x0
    s = idle(); s.we_e = 1; s.a3 = 7; s.we_w2 = 1; s.a4w2 = 7; s.a2 = 7;
    apply("fwd_w_over_w2", mk(2'b00, 2'b01, 0, 0, 0, 0, 1));
    s = idle(); s.we_e = 1; s.we_w2 = 1; s.we_w = 1;
    apply("fwd_x0", mk(2'b00, 2'b00, 0, 0, 0, 0, 1));
    s = idle(); s.we_e = 1; s.a3 = 3; s.a1 = 3; s.we_w2 = 1; s.a4w2 = 9; s.a2 = 9;
    apply("fwd_mixed", mk(2'b01, 2'b10, 0, 0, 0, 0, 1));

    // branch, and branch deferred by load-use
    s = idle(); s.pcsrc = 2'b01;                        apply("br", mk(2'b00, 2'b00, 0, 1, 0, 0, 1));
    s = idle(); s.pcsrc = 2'b01; s.we_w = 1; s.a4 = 6; s.a2 = 6;
    apply("br_lu", mk(2'b00, 2'b00, 1, 0, 0, 0, 1));
    s = idle(); s.pcsrc = 2'b01; s.we_w2 = 1; s.a4w2 = 6; s.a2 = 6;
    apply("br_after_lu", mk(2'b00, 2'b10, 0, 1, 0, 0, 2));
    s = idle();                                         apply("idle2", mk(2'b00, 2'b00, 0, 0, 0, 0, 2));

    // multi-cycle op, done after 5 busy cycles; PCSrcE ignored while busy
    s = idle(); s.mcs = 1;                              apply("mc_launch", mk(2'b00, 2'b00, 1, 0, 0, 0, 2));
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.mcs = 1; s.pcsrc = 2'b01;
      apply("mc_busy", mk(2'b00, 2'b00, 1, 0, 1, 0, CW'(3 + i)));
    end
    s = idle(); s.mcs = 1; s.mcd = 1;                   apply("mc_done", mk(2'b00, 2'b00, 1, 0, 1, 0, 7));
    s = idle(); s.mcs = 1;                              apply("mc_ack_mask", mk(2'b00, 2'b00, 0, 0, 0, 0, 8));
    s = idle();                                         apply("idle3", mk(2'b00, 2'b00, 0, 0, 0, 0, 8));
    s = idle(); s.mcs = 1; s.mcd = 1; s.pcsrc = 2'b01;  apply("mc_single", mk(2'b00, 2'b00, 0, 1, 0, 0, 8));
    s = idle();                                         apply("idle4", mk(2'b00, 2'b00, 0, 0, 0, 0, 8));

    // timeout abort after 8 stalled cycles; counter saturates at 15
    s = idle(); s.mcs = 1;                              apply("to_launch", mk(2'b00, 2'b00, 1, 0, 0, 0, 8));
    for (int i = 0; i < 7; i++) begin
      s = idle(); s.mcs = 1;
      apply("to_busy", mk(2'b00, 2'b00, 1, 0, 1, 0, CW'(9 + i)));
    end
    s = idle();                                         apply("to_abort", mk(2'b00, 2'b00, 0, 0, 0, 1, 15));
    s = idle();                                         apply("to_sticky", mk(2'b00, 2'b00, 0, 0, 0, 1, 15));

    // async reset in the middle of MC_BUSY
    s = idle(); s.mcs = 1;                              apply("mc_launch2", mk(2'b00, 2'b00, 1, 0, 0, 1, 15));
    s = idle(); s.mcs = 1;                              apply("cnt_saturate", mk(2'b00, 2'b00, 1, 0, 1, 1, 15));
    s = '0; s.mcs = 1;                                  apply("async_reset", mk(2'b00, 2'b00, 0, 0, 0, 0, 0));
    s = idle(); s.mcd = 1;                              apply("late_done", mk(2'b00, 2'b00, 0, 0, 0, 0, 0));
    s = idle();                                         apply("post_reset", mk(2'b00, 2'b00, 0, 0, 0, 0, 0));

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
